// File: rtl/boss_damage_ctrl.sv
// Boss damage scheduler: round-robin hit arbitration, saturating HP, invulnerability window.
// Optional HP regeneration is enabled by defining BOSS_REGEN_EN.
module boss_damage_ctrl #(
    parameter int N_SRC         = 3,
    parameter int BOSS_HP_MAX   = 100,
    parameter int INVULN_FRAMES = 8,
    parameter int PHASE2_HP     = 60,
`ifdef BOSS_REGEN_EN
    parameter int PHASE3_HP     = 25,
    parameter int REGEN_FRAMES  = 120
`else
    parameter int PHASE3_HP     = 25
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [1:0]         game_active,
    input  logic               game_start,
    input  logic [N_SRC-1:0]   hit_req,
    input  logic [4*N_SRC-1:0] hit_dmg,
    output logic [N_SRC-1:0]   hit_grant,
    output logic [6:0]         boss_hp,
    output logic [1:0]         boss_phase,
    output logic               boss_hurt,
    output logic               boss_defeated
);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [1:0] ST_READY  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;
    localparam logic [6:0] HP_MAX    = 7'(BOSS_HP_MAX);

    // A zero damage nibble still costs one HP; subtraction clamps at zero.
    function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [3:0] dmg);
        logic [6:0] dmg7;
        dmg7 = (dmg == 4'd0) ? 7'd1 : {3'd0, dmg};
        return (dmg7 >= hp) ? 7'd0 : (hp - dmg7);
    endfunction

    function automatic logic [1:0] phase_of(input logic [6:0] hp);
        if (hp > 7'(PHASE2_HP)) begin
            return 2'd0;
        end else if (hp > 7'(PHASE3_HP)) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    logic [1:0]       state_r, state_s;
    logic [7:0]       inv_cnt_r, inv_cnt_s;
    logic [PTR_W-1:0] rr_ptr_r, rr_ptr_s;
    logic [PTR_W-1:0] idx_s, gidx_s;
    logic [6:0]       hp_s;
    logic [N_SRC-1:0] grant_s;
    logic [3:0]       dmg_arr_s [N_SRC];
    logic [3:0]       dmg_sel_s;
    logic             found_s;
    logic             qual_s;
`ifdef BOSS_REGEN_EN
    logic [15:0]      regen_cnt_r, regen_cnt_s;
`endif

    assign qual_s = frame_tick && (game_active == 2'd1);

    // Unpack per-source damage nibbles.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            dmg_arr_s[i] = hit_dmg[4*i +: 4];
        end
    end

    // Round-robin search starting at the pointer, ascending with wrap.
    always_comb begin
        found_s   = 1'b0;
        gidx_s    = '0;
        idx_s     = '0;
        dmg_sel_s = 4'd0;
        for (int k = 0; k < N_SRC; k++) begin
            idx_s = PTR_W'((int'(rr_ptr_r) + k) % N_SRC);
            if (!found_s && hit_req[idx_s]) begin
                found_s   = 1'b1;
                gidx_s    = idx_s;
                dmg_sel_s = dmg_arr_s[idx_s];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state logic for FSM, HP, pointer and grant.
    always_comb begin
        state_s   = state_r;
        inv_cnt_s = inv_cnt_r;
        rr_ptr_s  = rr_ptr_r;
        hp_s      = boss_hp;
        grant_s   = '0;
`ifdef BOSS_REGEN_EN
        regen_cnt_s = regen_cnt_r;
`endif
        if (qual_s) begin
            case (state_r)
                ST_READY: begin
                    if (found_s) begin
                        grant_s[gidx_s] = 1'b1;
                        hp_s     = sat_sub(boss_hp, dmg_sel_s);
                        rr_ptr_s = (gidx_s == PTR_W'(N_SRC - 1)) ? '0 : gidx_s + PTR_W'(1);
`ifdef BOSS_REGEN_EN
                        regen_cnt_s = 16'd0;
`endif
                        if (hp_s == 7'd0) begin
                            state_s   = ST_DEAD;
                            inv_cnt_s = 8'd0;
                        end else begin
                            state_s   = ST_INVULN;
                            inv_cnt_s = 8'(INVULN_FRAMES);
                        end
                    end else begin
`ifdef BOSS_REGEN_EN
                        if ((boss_hp > 7'd0) && (boss_hp < HP_MAX)) begin
                            if (regen_cnt_r + 16'd1 >= 16'(REGEN_FRAMES)) begin
                                hp_s        = boss_hp + 7'd1;
                                regen_cnt_s = 16'd0;
                            end else begin
                                regen_cnt_s = regen_cnt_r + 16'd1;
                            end
                        end else begin
                            regen_cnt_s = 16'd0;
                        end
`else
                        hp_s = boss_hp;
`endif
                    end
                end
                // Leaving on the frame the counter would hit zero yields exactly INVULN_FRAMES ignored frames.
                ST_INVULN: begin
                    if (inv_cnt_r <= 8'd1) begin
                        state_s   = ST_READY;
                        inv_cnt_s = 8'd0;
                    end else begin
                        inv_cnt_s = inv_cnt_r - 8'd1;
                    end
                end
                ST_DEAD: begin
                    state_s = ST_DEAD;
                end
                default: begin
                    state_s   = ST_READY;
                    inv_cnt_s = 8'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs; game_start reloads exactly like rst.
    always_ff @(posedge clk) begin
        if (rst || game_start) begin
            state_r       <= ST_READY;
            inv_cnt_r     <= 8'd0;
            rr_ptr_r      <= '0;
            boss_hp       <= HP_MAX;
            hit_grant     <= '0;
            boss_phase    <= 2'd0;
            boss_hurt     <= 1'b0;
            boss_defeated <= 1'b0;
`ifdef BOSS_REGEN_EN
            regen_cnt_r   <= 16'd0;
`endif
        end else begin
            state_r       <= state_s;
            inv_cnt_r     <= inv_cnt_s;
            rr_ptr_r      <= rr_ptr_s;
            boss_hp       <= hp_s;
            hit_grant     <= grant_s;
            boss_phase    <= phase_of(hp_s);
            boss_hurt     <= (state_s == ST_INVULN);
            boss_defeated <= (hp_s == 7'd0);
`ifdef BOSS_REGEN_EN
            regen_cnt_r   <= regen_cnt_s;
`endif
        end
    end
endmodule

// File: tb/tb_boss_damage_ctrl.sv
// Scoreboard bench for boss_damage_ctrl (default parameters, regen disabled).
module tb_boss_damage_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  game_active = 2'd1;
    logic        game_start = 1'b0;
    logic [2:0]  hit_req = 3'b000;
    logic [11:0] hit_dmg = 12'h000;
    logic [2:0]  hit_grant;
    logic [6:0]  boss_hp;
    logic [1:0]  boss_phase;
    logic        boss_hurt;
    logic        boss_defeated;

    typedef struct packed {
        logic [2:0] g;
        logic [6:0] hp;
        logic [1:0] ph;
        logic       hurt;
        logic       dead;
    } exp_t;

    exp_t exp_q[$];
    exp_t act;
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    logic due = 1'b0;
    logic mon_en = 1'b0;

    boss_damage_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .game_start(game_start), .hit_req(hit_req), .hit_dmg(hit_dmg),
        .hit_grant(hit_grant), .boss_hp(boss_hp), .boss_phase(boss_phase),
        .boss_hurt(boss_hurt), .boss_defeated(boss_defeated)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        due <= frame_tick | game_start | rst;
        if (rst) mon_en <= 1'b1;
    end

    // Monitor: pops an expectation for every cycle that follows a frame/reload, else grant must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            act = '{hit_grant, boss_hp, boss_phase, boss_hurt, boss_defeated};
            if (due) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_out: output %h with no expectation queued", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        miscompares++;
                        $display("FAIL frame_out @%0t: got grant=%b hp=%0d ph=%0d hurt=%b dead=%b, expected grant=%b hp=%0d ph=%0d hurt=%b dead=%b",
                                 $time, act.g, act.hp, act.ph, act.hurt, act.dead, e.g, e.hp, e.ph, e.hurt, e.dead);
                    end
                end
            end else begin
                vectors++;
                if (hit_grant !== 3'b000) begin
                    miscompares++;
                    $display("FAIL grant_pulse @%0t: got %b, expected 000", $time, hit_grant);
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] g, input logic [6:0] hp, input logic [1:0] ph,
                            input logic hurt, input logic dead);
        exp_t x;
        x = '{g, hp, ph, hurt, dead};
        exp_q.push_back(x);
    endtask

    task automatic tick(input logic [2:0] req, input logic [11:0] dmg, input logic [2:0] g,
                        input logic [6:0] hp, input logic [1:0] ph, input logic hurt, input logic dead);
        @(negedge clk);
        hit_req = req; hit_dmg = dmg; frame_tick = 1'b1;
        push_exp(g, hp, ph, hurt, dead);
        @(negedge clk);
        frame_tick = 1'b0; hit_req = 3'b000;
    endtask

    // Eight ignored frames after a hit: hurt stays high for seven, drops on the eighth.
    task automatic invuln_run(input logic [2:0] req, input logic [11:0] dmg, input logic [6:0] hp,
                              input logic [1:0] ph);
        for (int i = 0; i < 7; i++) tick(req, dmg, 3'b000, hp, ph, 1'b1, 1'b0);
        tick(req, dmg, 3'b000, hp, ph, 1'b0, 1'b0);
    endtask

    task automatic gstart(input logic ft, input logic [2:0] req, input logic [11:0] dmg);
        @(negedge clk);
        game_start = 1'b1; frame_tick = ft; hit_req = req; hit_dmg = dmg;
        push_exp(3'b000, 7'd100, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        game_start = 1'b0; frame_tick = 1'b0; hit_req = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push_exp(3'b000, 7'd100, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Single hit, held request regranted on frame 10.
        tick(3'b001, 12'h003, 3'b001, 7'd97, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b001, 12'h003, 7'd97, 2'd0);
        tick(3'b001, 12'h003, 3'b001, 7'd94, 2'd0, 1'b1, 1'b0);
        // Leaving game_active freezes the invulnerability counter.
        game_active = 2'd0;
        tick(3'b001, 12'h003, 3'b000, 7'd94, 2'd0, 1'b1, 1'b0);
        tick(3'b001, 12'h003, 3'b000, 7'd94, 2'd0, 1'b1, 1'b0);
        game_active = 2'd2;
        tick(3'b001, 12'h003, 3'b000, 7'd94, 2'd0, 1'b1, 1'b0);
        game_active = 2'd1;
        invuln_run(3'b001, 12'h003, 7'd94, 2'd0);
        tick(3'b001, 12'h003, 3'b001, 7'd91, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd91, 2'd0);

        // Round-robin from a fresh reload: src0=1, src1=2, src2=3.
        gstart(1'b0, 3'b000, 12'h000);
        tick(3'b111, 12'h321, 3'b001, 7'd99, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b111, 12'h321, 7'd99, 2'd0);
        tick(3'b111, 12'h321, 3'b010, 7'd97, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b111, 12'h321, 7'd97, 2'd0);
        tick(3'b111, 12'h321, 3'b100, 7'd94, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b111, 12'h321, 7'd94, 2'd0);
        tick(3'b111, 12'h321, 3'b001, 7'd93, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h321, 7'd93, 2'd0);
        tick(3'b101, 12'h321, 3'b100, 7'd90, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h321, 7'd90, 2'd0);

        // Request pulse between frames is not latched.
        @(negedge clk);
        hit_req = 3'b010; hit_dmg = 12'h0F0;
        @(negedge clk);
        hit_req = 3'b000;
        tick(3'b000, 12'h0F0, 3'b000, 7'd90, 2'd0, 1'b0, 1'b0);

        // Zero damage and phase thresholds.
        tick(3'b001, 12'h00F, 3'b001, 7'd75, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd75, 2'd0);
        tick(3'b001, 12'h00E, 3'b001, 7'd61, 2'd0, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd61, 2'd0);
        tick(3'b001, 12'h000, 3'b001, 7'd60, 2'd1, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd60, 2'd1);
        tick(3'b001, 12'h00F, 3'b001, 7'd45, 2'd1, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd45, 2'd1);
        tick(3'b001, 12'h00F, 3'b001, 7'd30, 2'd1, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd30, 2'd1);
        tick(3'b001, 12'h004, 3'b001, 7'd26, 2'd1, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd26, 2'd1);
        tick(3'b001, 12'h000, 3'b001, 7'd25, 2'd2, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd25, 2'd2);
        tick(3'b001, 12'h00F, 3'b001, 7'd10, 2'd2, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd10, 2'd2);
        tick(3'b001, 12'h005, 3'b001, 7'd5, 2'd2, 1'b1, 1'b0);
        invuln_run(3'b000, 12'h000, 7'd5, 2'd2);

        // Saturating death, then requests are ignored.
        tick(3'b010, 12'h0F0, 3'b010, 7'd0, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(3'b111, 12'hFFF, 3'b000, 7'd0, 2'd2, 1'b0, 1'b1);

        // Reload from DEAD, then reload concurrent with a hit frame.
        gstart(1'b0, 3'b000, 12'h000);
        gstart(1'b1, 3'b001, 12'h003);
        tick(3'b111, 12'h321, 3'b001, 7'd99, 2'd0, 1'b1, 1'b0);

        // Reset mid-invulnerability restores everything, including the pointer.
        do_reset();
        tick(3'b010, 12'h321, 3'b010, 7'd98, 2'd0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
